// File: rtl/uart_cmd_pkg.sv
// Shared ASCII constants, state encodings and reply helpers for the UART command parser.
// Reply words are packed first-byte-in-MSB so the sender can shift out from the top.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Q  = 8'h3F;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_0  = 8'h30;

    localparam int REPLY_LEN = 4;

    localparam logic [1:0] PS_CMD  = 2'd0;
    localparam logic [1:0] PS_ARG  = 2'd1;
    localparam logic [1:0] PS_EOL  = 2'd2;
    localparam logic [1:0] PS_SKIP = 2'd3;

    localparam logic [1:0] SS_IDLE = 2'd0;
    localparam logic [1:0] SS_SEND = 2'd1;
    localparam logic [1:0] SS_GAP  = 2'd2;
    localparam logic [1:0] SS_WAIT = 2'd3;

    typedef enum logic [1:0] {
        ST_CMD  = PS_CMD,
        ST_ARG  = PS_ARG,
        ST_EOL  = PS_EOL,
        ST_SKIP = PS_SKIP
    } parse_state_t;

    typedef enum logic [1:0] {
        SND_IDLE = SS_IDLE,
        SND_SEND = SS_SEND,
        SND_GAP  = SS_GAP,
        SND_WAIT = SS_WAIT
    } send_state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LED,
        CMD_AUTO,
        CMD_QUERY
    } cmd_t;

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic [31:0] reply_word(input logic [7:0] b0, input logic [7:0] b1);
        return {b0, b1, ASCII_CR, ASCII_LF};
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-level UART side of the command parser plus its LED override outputs.
// master = board/bench side, slave = parser.
interface uart_cmd_parser_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_break;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       led_override;
    logic [2:0] led_value;
    logic       rx_drop;

    modport master (
        output rx_valid, rx_data, rx_break, tx_busy,
        input  tx_en, tx_data, led_override, led_value, rx_drop
    );

    modport slave (
        input  rx_valid, rx_data, rx_break, tx_busy,
        output tx_en, tx_data, led_override, led_value, rx_drop
    );
endinterface

// File: rtl/uart_reply_sender.sv
// Holds one 4-byte reply and feeds it to uart_tx; first byte can issue the cycle after load.
// Each byte waits for !tx_busy, then a one-cycle gap lets uart_tx raise busy before re-checking.
module uart_reply_sender
    import uart_cmd_pkg::*;
(
    input  logic        CLK_IN,
    input  logic        RST_N,
    input  logic        load,
    input  logic [31:0] bytes,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        busy
);

    send_state_t state, state_nxt;
    logic [31:0] buf_q;
    logic [2:0]  idx;
    logic [2:0]  len;

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            state <= SND_IDLE;
            buf_q <= '0;
            idx   <= '0;
            len   <= '0;
        end else begin
            state <= state_nxt;
            if (load && (state == SND_IDLE)) begin
                buf_q <= bytes;
                idx   <= '0;
                len   <= 3'(REPLY_LEN);
            end else if (tx_en) begin
                buf_q <= {buf_q[23:0], 8'h00};
                idx   <= idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tx_en     = 1'b0;
        case (state)
            SND_IDLE: if (load) state_nxt = SND_SEND;
            SND_SEND: begin
                if (!tx_busy) begin
                    tx_en     = 1'b1;
                    state_nxt = SND_GAP;
                end
            end
            SND_GAP:  state_nxt = (idx < len) ? SND_WAIT : SND_IDLE;
            SND_WAIT: if (!tx_busy) state_nxt = SND_SEND;
            default:  state_nxt = SND_IDLE;
        endcase
    end

    assign tx_data = tx_en ? buf_q[31:24] : 8'h00;
    assign busy    = (state != SND_IDLE);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "L<d>", "A", "?" command lines from uart_rx and drives the LED override and ASCII replies.
// Side effects land one cycle after the EOL byte; bytes arriving while a reply is in flight are dropped.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [2:0] LED_RESET = 3'b001,
    parameter bit         REPLY_EN  = 1'b1
) (
    input  logic              CLK_IN,
    input  logic              RST_N,
    uart_cmd_parser_if.slave  bus
);

    parse_state_t state, state_nxt;
    cmd_t         cmd_q, cmd_nxt;
    logic [2:0]   arg_q, arg_nxt;
    logic         exec, err, load, snd_busy, accept, brk, eol, is_digit;
    logic [31:0]  reply_bytes;

    // While a reply is in flight the parser neither consumes bytes nor reacts to BREAK.
    assign accept   = bus.rx_valid && !bus.rx_break && !snd_busy;
    assign brk      = bus.rx_break && !snd_busy;
    assign eol      = is_eol(bus.rx_data);
    assign is_digit = (bus.rx_data[7:3] == 5'b00110);

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        arg_nxt   = arg_q;
        exec      = 1'b0;
        err       = 1'b0;
        if (brk) begin
            state_nxt = ST_CMD;
        end else if (accept) begin
            case (state)
                ST_CMD: begin
                    if (bus.rx_data == ASCII_L) begin
                        state_nxt = ST_ARG;
                        cmd_nxt   = CMD_LED;
                    end else if (bus.rx_data == ASCII_A) begin
                        state_nxt = ST_EOL;
                        cmd_nxt   = CMD_AUTO;
                    end else if (bus.rx_data == ASCII_Q) begin
                        state_nxt = ST_EOL;
                        cmd_nxt   = CMD_QUERY;
                    end else if (!eol) begin
                        state_nxt = ST_SKIP;
                    end
                end
                ST_ARG: begin
                    if (is_digit) begin
                        state_nxt = ST_EOL;
                        arg_nxt   = bus.rx_data[2:0];
                    end else if (eol) begin
                        err       = 1'b1;
                        state_nxt = ST_CMD;
                    end else begin
                        state_nxt = ST_SKIP;
                    end
                end
                ST_EOL: begin
                    if (eol) begin
                        exec      = 1'b1;
                        state_nxt = ST_CMD;
                    end else begin
                        state_nxt = ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (eol) begin
                        err       = 1'b1;
                        state_nxt = ST_CMD;
                    end
                end
                default: state_nxt = ST_CMD;
            endcase
        end
    end

    // Query reports the LED state as it stands before this line, which '?' never changes.
    always_comb begin
        reply_bytes = reply_word(ASCII_O, ASCII_K);
        if (err) begin
            reply_bytes = reply_word(ASCII_E, ASCII_R);
        end else if (cmd_q == CMD_QUERY) begin
            reply_bytes = reply_word(ASCII_0 | {7'b0, bus.led_override},
                                     ASCII_0 | {5'b0, bus.led_value});
        end
    end

    assign load = REPLY_EN && (exec || err);

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            state            <= ST_CMD;
            cmd_q            <= CMD_NONE;
            arg_q            <= '0;
            bus.led_override <= 1'b0;
            bus.led_value    <= LED_RESET;
            bus.rx_drop      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_q       <= cmd_nxt;
            arg_q       <= arg_nxt;
            bus.rx_drop <= bus.rx_valid && snd_busy;
            if (exec && (cmd_q == CMD_LED)) begin
                bus.led_value    <= arg_q;
                bus.led_override <= 1'b1;
            end else if (exec && (cmd_q == CMD_AUTO)) begin
                bus.led_override <= 1'b0;
            end
        end
    end

    uart_reply_sender u_sender (
        .CLK_IN  (CLK_IN),
        .RST_N   (RST_N),
        .load    (load),
        .bytes   (reply_bytes),
        .tx_busy (bus.tx_busy),
        .tx_en   (bus.tx_en),
        .tx_data (bus.tx_data),
        .busy    (snd_busy)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: uart_tx busy model, reply capture, drop/break/reset scenarios.
module tb_uart_cmd_parser;

    logic CLK_IN = 1'b0;
    logic RST_N  = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    uart_cmd_parser_if bus ();
    uart_cmd_parser_if bus2 ();

    uart_cmd_parser #(.LED_RESET(3'b001), .REPLY_EN(1'b1)) dut (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    uart_cmd_parser #(.LED_RESET(3'b001), .REPLY_EN(1'b0)) dut_silent (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .bus    (bus2)
    );

    int vectors     = 0;
    int miscompares = 0;
    int busy_cnt    = 0;
    int drops       = 0;
    int tx2_cnt     = 0;
    logic [7:0] txq[$];

    assign bus.tx_busy  = (busy_cnt != 0);
    assign bus2.tx_busy = 1'b0;

    // uart_tx model: each accepted byte keeps it busy for 10 cycles.
    always @(posedge CLK_IN) begin
        if (bus.tx_en && bus.tx_busy) begin
            miscompares++;
            $display("FAIL tx_en_while_busy: tx_en=1 with tx_busy=1, required tx_en=0");
        end
        if (bus.tx_en) begin
            txq.push_back(bus.tx_data);
            busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (bus.rx_drop) drops++;
        if (bus2.tx_en) tx2_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK_IN);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge CLK_IN);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic pulse_break();
        bus.rx_break = 1'b1;
        @(negedge CLK_IN);
        bus.rx_break = 1'b0;
    endtask

    task automatic get_reply(output logic [31:0] r);
        int t = 0;
        while (txq.size() < 4 && t < 300) begin
            @(negedge CLK_IN);
            t++;
        end
        if (txq.size() >= 4) begin
            r = {txq[0], txq[1], txq[2], txq[3]};
            repeat (4) void'(txq.pop_front());
        end else begin
            r = 'x;
        end
        idle(12);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        idle(3);
        vectors++; if (bus.tx_en !== 1'b0) begin miscompares++; $display("FAIL reset_tx_en: got %b want 0", bus.tx_en); end
        vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        vectors++; if (bus.led_override !== 1'b0) begin miscompares++; $display("FAIL reset_led_override: got %b want 0", bus.led_override); end
        vectors++; if (bus.led_value !== 3'b001) begin miscompares++; $display("FAIL reset_led_value: got %b want 001", bus.led_value); end
        vectors++; if (bus.rx_drop !== 1'b0) begin miscompares++; $display("FAIL reset_rx_drop: got %b want 0", bus.rx_drop); end
        RST_N = 1'b1;
        idle(2);
    endtask

    task automatic test_led_cmd();
        logic [31:0] r;
        send_str("L5");
        send_byte(8'h0D);
        vectors++; if (bus.tx_en !== 1'b1) begin miscompares++; $display("FAIL l5_first_tx_en: got %b want 1", bus.tx_en); end
        vectors++; if (bus.tx_data !== 8'h4F) begin miscompares++; $display("FAIL l5_first_tx_data: got %h want 4f", bus.tx_data); end
        vectors++; if (bus.led_value !== 3'b101) begin miscompares++; $display("FAIL l5_led_value: got %b want 101", bus.led_value); end
        vectors++; if (bus.led_override !== 1'b1) begin miscompares++; $display("FAIL l5_led_override: got %b want 1", bus.led_override); end
        get_reply(r);
        vectors++; if (r !== 32'h4F4B0D0A) begin miscompares++; $display("FAIL l5_reply: got %h want 4f4b0d0a", r); end
        send_byte(8'h0A);
        idle(40);
        vectors++; if (txq.size() != 0) begin miscompares++; $display("FAIL blank_lf_reply: got %0d bytes want 0", txq.size()); end
    endtask

    task automatic test_query_auto();
        logic [31:0] r;
        send_str("?\n");
        get_reply(r);
        vectors++; if (r !== 32'h31350D0A) begin miscompares++; $display("FAIL query_reply: got %h want 31350d0a", r); end
        send_str("A\n");
        get_reply(r);
        vectors++; if (r !== 32'h4F4B0D0A) begin miscompares++; $display("FAIL auto_reply: got %h want 4f4b0d0a", r); end
        vectors++; if (bus.led_override !== 1'b0) begin miscompares++; $display("FAIL auto_led_override: got %b want 0", bus.led_override); end
        vectors++; if (bus.led_value !== 3'b101) begin miscompares++; $display("FAIL auto_led_value: got %b want 101", bus.led_value); end
    endtask

    task automatic test_errors();
        logic [31:0] r;
        string cmds[4];
        cmds[0] = "L9\n"; cmds[1] = "X\n"; cmds[2] = "LL\n"; cmds[3] = "L\n";
        for (int i = 0; i < 4; i++) begin
            send_str(cmds[i]);
            get_reply(r);
            vectors++; if (r !== 32'h45520D0A) begin miscompares++; $display("FAIL err_reply_%0d: got %h want 45520d0a", i, r); end
        end
        vectors++; if (bus.led_value !== 3'b101) begin miscompares++; $display("FAIL err_led_value: got %b want 101", bus.led_value); end
    endtask

    task automatic test_drop();
        logic [31:0] r;
        int d0;
        d0 = drops;
        send_str("?\n");
        idle(2);
        send_byte(8'h4C);
        idle(3);
        send_byte(8'h31);
        idle(3);
        send_byte(8'h0A);
        get_reply(r);
        vectors++; if (r !== 32'h30350D0A) begin miscompares++; $display("FAIL drop_reply: got %h want 30350d0a", r); end
        vectors++; if (drops - d0 != 3) begin miscompares++; $display("FAIL drop_count: got %0d want 3", drops - d0); end
        vectors++; if (bus.led_value !== 3'b101) begin miscompares++; $display("FAIL drop_led_value: got %b want 101", bus.led_value); end
    endtask

    task automatic test_break();
        logic [31:0] r;
        send_str("L3");
        pulse_break();
        send_byte(8'h0A);
        idle(60);
        vectors++; if (txq.size() != 0) begin miscompares++; $display("FAIL break_no_reply: got %0d bytes want 0", txq.size()); end
        vectors++; if (bus.led_value !== 3'b101) begin miscompares++; $display("FAIL break_led_value: got %b want 101", bus.led_value); end
        bus.rx_break = 1'b1;
        send_byte(8'h4C);
        bus.rx_break = 1'b0;
        send_str("3\n");
        get_reply(r);
        vectors++; if (r !== 32'h45520D0A) begin miscompares++; $display("FAIL break_with_byte_reply: got %h want 45520d0a", r); end
        send_str("L6\n");
        idle(5);
        pulse_break();
        idle(20);
        pulse_break();
        get_reply(r);
        vectors++; if (r !== 32'h4F4B0D0A) begin miscompares++; $display("FAIL break_in_reply: got %h want 4f4b0d0a", r); end
        vectors++; if (bus.led_value !== 3'b110) begin miscompares++; $display("FAIL break_in_reply_led: got %b want 110", bus.led_value); end
    endtask

    task automatic test_reset_mid_reply();
        int t = 0;
        int n;
        send_str("?\n");
        while (txq.size() < 1 && t < 100) begin
            @(negedge CLK_IN);
            t++;
        end
        vectors++; if (txq.size() < 1 || txq[0] !== 8'h31) begin miscompares++; $display("FAIL midrst_first_byte: got %0d bytes want first byte 31", txq.size()); end
        idle(3);
        RST_N = 1'b0;
        @(negedge CLK_IN);
        vectors++; if (bus.tx_en !== 1'b0) begin miscompares++; $display("FAIL midrst_tx_en: got %b want 0", bus.tx_en); end
        vectors++; if (bus.led_value !== 3'b001) begin miscompares++; $display("FAIL midrst_led_value: got %b want 001", bus.led_value); end
        vectors++; if (bus.led_override !== 1'b0) begin miscompares++; $display("FAIL midrst_led_override: got %b want 0", bus.led_override); end
        RST_N = 1'b1;
        n = txq.size();
        idle(100);
        vectors++; if (txq.size() != n) begin miscompares++; $display("FAIL midrst_no_more_tx: got %0d bytes want %0d", txq.size(), n); end
        txq.delete();
    endtask

    task automatic test_no_reply();
        logic [7:0] seq[3];
        seq[0] = 8'h4C; seq[1] = 8'h32; seq[2] = 8'h0A;
        for (int i = 0; i < 3; i++) begin
            bus2.rx_data  = seq[i];
            bus2.rx_valid = 1'b1;
            @(negedge CLK_IN);
            bus2.rx_valid = 1'b0;
        end
        idle(30);
        vectors++; if (bus2.led_value !== 3'b010) begin miscompares++; $display("FAIL silent_led_value: got %b want 010", bus2.led_value); end
        vectors++; if (bus2.led_override !== 1'b1) begin miscompares++; $display("FAIL silent_led_override: got %b want 1", bus2.led_override); end
        vectors++; if (tx2_cnt != 0) begin miscompares++; $display("FAIL silent_tx_en: got %0d pulses want 0", tx2_cnt); end
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_break  = 1'b0;
        bus2.rx_valid = 1'b0;
        bus2.rx_data  = 8'h00;
        bus2.rx_break = 1'b0;
        @(negedge CLK_IN);
        test_reset();
        test_led_cmd();
        test_query_auto();
        test_errors();
        test_drop();
        test_break();
        test_reset_mid_reply();
        test_no_reply();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits between uart_rx and uart_tx in the board top; replaces the raw byte echo path.
- Parses single-line ASCII commands from received bytes.
- Drives an RGB LED override value and sends a short ASCII reply per command through the uart_tx handshake.
- The top muxes led_value over the free-running LED shifter while led_override is high.

Parameters:
- LED_RESET, 3'b001, led_value after reset.
- REPLY_EN, 1, 1 = send replies; 0 = execute commands silently (tx_en held 0).

Ports:
- CLK_IN  in  1  system clock
- RST_N  in  1  reset
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- rx_data  in  8  received byte
- rx_break  in  1  BREAK detected on the line
- tx_busy  in  1  uart_tx is serialising a byte
- tx_en  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit; valid while tx_en=1
- led_override  out  1  1 = led_value drives the LEDs
- led_value  out  3  LED pattern from the last 'L' command
- rx_drop  out  1  one-cycle pulse: byte discarded because a reply is in progress

Behaviour:
- Clocking and reset: one clock, CLK_IN. Reset is synchronous, active-low on RST_N.
- Reset values: state=CMD, tx_en=0, tx_data=0, led_override=0, led_value=LED_RESET, rx_drop=0, reply length=0.
- End of line (EOL): CR (0x0D) or LF (0x0A). In CMD, EOL is ignored with no reply, so CRLF and blank lines are harmless.
- Accepted commands (case-sensitive):
  - "L<d>EOL", d='0'..'7': led_value<=d[2:0], led_override<=1, reply "OK\r\n".
  - "AEOL": led_override<=0, led_value unchanged, reply "OK\r\n".
  - "?EOL": reply "<o><d>\r\n". o='1'/'0' for led_override; d is the ASCII digit of led_value.
  - Any other line: reply "ER\r\n" when its EOL arrives.
- State machine:
  - CMD: 'L'->ARG; 'A' or '?'->EOL (command latched); EOL->CMD; other->SKIP.
  - ARG: '0'..'7'->EOL (digit latched); EOL->error reply; other->SKIP.
  - EOL: EOL->execute + load reply->SEND; other->SKIP.
  - SKIP: ignore bytes until EOL, then load "ER\r\n"->SEND.
  - SEND: if !tx_busy, tx_en=1 for one cycle with tx_data=buf[idx], idx++ ->GAP.
  - GAP: one cycle, so tx_busy has time to rise. Then go to WAIT if idx<len, else to CMD.
  - WAIT: when !tx_busy, return to SEND.
- Side-effect timing: command side effects (led_*) update in the cycle after the EOL byte is accepted, at the same edge the reply is loaded.
- Reply buffer: 4 bytes, 3-bit length. Every reply is exactly 4 bytes.
- With REPLY_EN=0: after execute, go straight to CMD; tx_en stays 0.
- Bytes during a reply: rx_valid in SEND/GAP/WAIT drops the byte and pulses rx_drop the next cycle. There is no queuing.
- tx_en never asserts while tx_busy=1 is sampled. The first byte of a reply may issue 1 cycle after load, if uart_tx is idle.
- rx_break: in CMD/ARG/EOL/SKIP, return to CMD with no reply and no side effect. In SEND/GAP/WAIT it is ignored and the reply completes.
- rx_valid and rx_break in the same cycle: the break wins and the byte is discarded.
- Reset mid-reply: abort immediately; tx_en=0 from the next cycle. Already-issued bytes complete inside uart_tx.

Decomposition:
- Shared package uart_cmd_pkg:
  - ASCII constants: CR, LF, 'L', 'A', '?', 'O', 'K', 'E', 'R', '0'.
  - State encoding localparams.
  - REPLY_LEN=4.
- Sub-module uart_reply_sender: 4-byte buffer plus the SEND/GAP/WAIT handshake.
  - Inputs: load, bytes[31:0], tx_busy.
  - Outputs: tx_en, tx_data, busy.
  - Parser FSM stays in uart_cmd_parser.

Test Plan:
- Reset, then "L5\r\n" with a tx_busy model (10 cycles busy per byte) -> led_value=3'b101, led_override=1; tx bytes 0x4F,0x4B,0x0D,0x0A; blank LF ignored.
- "?\n" after the above -> reply "15\r\n" (0x31,0x35,0x0D,0x0A). Then "A\n" -> "OK\r\n", led_override=0, led_value still 5.
- "L9\n", "X\n", "LL\n", "L\n" -> each reply "ER\r\n"; led_value unchanged.
- Bytes injected during a reply -> rx_drop pulses once per byte; reply intact; no tx_en ever while tx_busy=1 (assertion).
- "L3" then rx_break, then "\n" -> no reply, led_value unchanged. Break during a reply -> full reply sent.
- RST_N=0 for 1 cycle in the middle of a reply -> outputs at reset values on the next edge; no further tx_en. REPLY_EN=0 build: "L2\n" -> led_value=2, tx_en never asserted.
